frame_wr_if: RTL and testbench

FRAME_WR_IF -- requirements
Module: frame_wr_if

---
 rtl/frame_if_pkg.sv | 21 ++
 rtl/sync_fifo_w128.sv | 56 +++++
 rtl/frame_wr_if.sv | 139 +++++++++++++
 tb/tb_frame_wr_if.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_if_pkg.sv
// Shared types and defaults for the frame write interface: FSM encoding,
// burst geometry and the pixel byte-order helper.
package frame_if_pkg;

  typedef enum logic [1:0] {
    ws_idle = 2'd0,
    ws_wait = 2'd1,
    ws_req  = 2'd2,
    ws_done = 2'd3
  } ws_state_t;

  localparam int BURST_LEN_BYTES_DFLT   = 16;
  localparam int ADDRESS_INCREMENT_DFLT = 8;
  localparam int BEAT_BYTES             = 16;

  // Pixel words arrive little-endian; memory wants them big-endian per word.
  function automatic logic [31:0] byte_swap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/sync_fifo_w128.sv
// Single-clock 128-bit first-word-fall-through FIFO with occupancy count and
// synchronous clear; pushes when full and pops when empty are dropped.
module sync_fifo_w128 #(
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic [127:0] push_data,
  input  logic         pop,
  output logic [127:0] pop_data,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  logic [127:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/frame_wr_if.sv
// Packs 32-bit pixel words into 128-bit beats and issues one held MIG write
// request per buffered beat until the job's byte count is written.
module frame_wr_if
  import frame_if_pkg::*;
#(
  parameter int  BURST_LEN_BYTES   = BURST_LEN_BYTES_DFLT,
  parameter int  ADDRESS_INCREMENT = ADDRESS_INCREMENT_DFLT,
  parameter int  IB_DEPTH          = 16,
  localparam int CW                = $clog2(IB_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_clk_n,
  input  logic          write_start,
  input  logic          write_abort,
  input  logic [29:0]   write_addr,
  input  logic [23:0]   write_count,
  input  logic          pix_valid,
  input  logic [31:0]   pix_data,
  output logic          pix_ready,
  output logic          mem_wr_req,
  output logic [28:0]   mem_wr_addr,
  output logic [127:0]  mem_wr_data,
  input  logic          mem_wr_ack,
  output logic [CW-1:0] ib_count,
  output logic          busy,
  output logic          write_done
);

  ws_state_t    state;
  ws_state_t    state_nxt;
  logic [23:0]  wr_byte_cnt;
  logic [23:0]  accept_bytes_left;
  logic [1:0]   lane;
  logic [95:0]  pack_buf;
  logic         ib_full;
  logic         ib_empty;
  logic [127:0] ib_head;
  logic         pix_acc;
  logic         beat_push;
  logic         ack_take;
  logic         start_go;
  logic         issue;
  logic         addr_lsb_unused;

  // Memory addresses are 16-bit words, so the byte-address LSB is dropped.
  assign addr_lsb_unused = write_addr[0];

  assign busy      = (state != ws_idle);
  assign pix_ready = busy && (accept_bytes_left != '0) && !((lane == 2'd3) && ib_full);
  assign pix_acc   = pix_valid && pix_ready;
  assign beat_push = pix_acc && (lane == 2'd3);
  assign ack_take  = (state == ws_req) && mem_wr_req && mem_wr_ack;
  assign start_go  = (state == ws_idle) && write_start;
  assign issue     = (state == ws_wait) && !ib_empty;

  always_ff @(posedge clk or negedge reset_clk_n) begin
    if (!reset_clk_n) state <= ws_idle;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (write_abort) begin
      state_nxt = ws_idle;
    end else begin
      case (state)
        ws_idle: if (write_start) state_nxt = (write_count[23:4] == '0) ? ws_done : ws_wait;
        ws_wait: if (!ib_empty)   state_nxt = ws_req;
        ws_req:  if (ack_take)
                   state_nxt = (wr_byte_cnt == 24'(BURST_LEN_BYTES)) ? ws_done : ws_wait;
        ws_done: state_nxt = ws_idle;
        default: state_nxt = ws_idle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_clk_n) begin
    if (!reset_clk_n) begin
      mem_wr_req        <= 1'b0;
      mem_wr_addr       <= '0;
      mem_wr_data       <= '0;
      write_done        <= 1'b0;
      wr_byte_cnt       <= '0;
      accept_bytes_left <= '0;
      lane              <= '0;
      pack_buf          <= '0;
    end else if (write_abort) begin
      mem_wr_req        <= 1'b0;
      write_done        <= 1'b0;
      wr_byte_cnt       <= '0;
      accept_bytes_left <= '0;
      lane              <= '0;
    end else begin
      write_done <= (state == ws_done);
      if (start_go) begin
        mem_wr_addr       <= write_addr[29:1];
        wr_byte_cnt       <= write_count & 24'hFF_FFF0;
        accept_bytes_left <= write_count & 24'hFF_FFF0;
      end
      // Request fields are captured once and held until the ack lands.
      if (issue) begin
        mem_wr_req  <= 1'b1;
        mem_wr_data <= ib_head;
      end
      if (ack_take) begin
        mem_wr_req  <= 1'b0;
        mem_wr_addr <= mem_wr_addr + 29'(ADDRESS_INCREMENT);
        wr_byte_cnt <= wr_byte_cnt - 24'(BURST_LEN_BYTES);
      end
      if (pix_acc) begin
        case (lane)
          2'd0:    pack_buf[95:64] <= byte_swap32(pix_data);
          2'd1:    pack_buf[63:32] <= byte_swap32(pix_data);
          2'd2:    pack_buf[31:0]  <= byte_swap32(pix_data);
          default: pack_buf        <= pack_buf;
        endcase
        lane <= lane + 2'd1;
      end
      if (beat_push) accept_bytes_left <= accept_bytes_left - 24'(BEAT_BYTES);
    end
  end

  // The fourth word bypasses pack_buf so a beat enters the buffer the cycle it completes.
  sync_fifo_w128 #(
    .DEPTH     (IB_DEPTH)
  ) u_ib (
    .clk       (clk),
    .rst_n     (reset_clk_n),
    .clr       (write_abort),
    .push      (beat_push),
    .push_data ({pack_buf, byte_swap32(pix_data)}),
    .pop       (ack_take),
    .pop_data  (ib_head),
    .full      (ib_full),
    .empty     (ib_empty),
    .count     (ib_count)
  );

endmodule

// File: tb/tb_frame_wr_if.sv
// Self-checking bench for frame_wr_if: randomized jobs against a queue-based
// model of the expected MIG request stream, plus directed corner scenarios.
module tb_frame_wr_if;

  localparam int IB_DEPTH = 16;
  localparam int BUDGET   = 3000;

  logic         clk = 1'b0;
  logic         reset_clk_n;
  logic         write_start;
  logic         write_abort;
  logic [29:0]  write_addr;
  logic [23:0]  write_count;
  logic         pix_valid;
  logic [31:0]  pix_data;
  logic         pix_ready;
  logic         mem_wr_req;
  logic [28:0]  mem_wr_addr;
  logic [127:0] mem_wr_data;
  logic         mem_wr_ack;
  logic [4:0]   ib_count;
  logic         busy;
  logic         write_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_wr_if #(
    .BURST_LEN_BYTES   (16),
    .ADDRESS_INCREMENT (8),
    .IB_DEPTH          (IB_DEPTH)
  ) dut (
    .clk         (clk),
    .reset_clk_n (reset_clk_n),
    .write_start (write_start),
    .write_abort (write_abort),
    .write_addr  (write_addr),
    .write_count (write_count),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_ready   (pix_ready),
    .mem_wr_req  (mem_wr_req),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_ack  (mem_wr_ack),
    .ib_count    (ib_count),
    .busy        (busy),
    .write_done  (write_done)
  );

  function automatic logic [31:0] bswap(input logic [31:0] w);
    bswap = {<<8{w}};
  endfunction

  // Runs one job: model = list of (word address, beat) derived from start address and word list.
  task automatic drive_job(input string name, input logic [29:0] addr, input logic [23:0] cnt,
                           input logic [31:0] words[$], input int vpct, input int apct);
    int nbeats, widx, ridx, dones, cyc;
    logic stall;
    logic [28:0]  a;
    logic [28:0]  exp_addr[$];
    logic [127:0] exp_data[$];
    nbeats = int'(cnt[23:4]);
    widx = 0; ridx = 0; dones = 0; cyc = 0; stall = 1'b0;
    a = addr[29:1];
    for (int k = 0; k < nbeats; k++) begin
      exp_addr.push_back(a);
      a = a + 29'd8;
      exp_data.push_back({bswap(words[4*k]), bswap(words[4*k+1]),
                          bswap(words[4*k+2]), bswap(words[4*k+3])});
    end
    write_addr = addr; write_count = cnt; write_start = 1'b1;
    @(negedge clk);
    write_start = 1'b0;
    while (dones == 0 && cyc < BUDGET) begin
      if (write_done) dones++;
      if (mem_wr_req) begin
        checks++;
        if (ridx >= nbeats) begin
          errors++;
          $display("FAIL %s_extra_req: request beyond the %0d expected, addr=%h", name, nbeats, mem_wr_addr);
        end else if (mem_wr_addr !== exp_addr[ridx] || mem_wr_data !== exp_data[ridx]) begin
          errors++;
          $display("FAIL %s_req%0d: got addr=%h data=%h, want addr=%h data=%h",
                   name, ridx, mem_wr_addr, mem_wr_data, exp_addr[ridx], exp_data[ridx]);
        end
      end else if (stall) begin
        checks++; errors++;
        $display("FAIL %s_req_drop: req=0 without ack, want req=1 held", name);
      end
      pix_valid = (widx < words.size()) && ($urandom_range(99) < vpct);
      pix_data  = pix_valid ? words[widx] : $urandom;
      if (pix_valid && pix_ready) widx++;
      mem_wr_ack = ($urandom_range(99) < apct);
      if (mem_wr_req && mem_wr_ack) ridx++;
      stall = mem_wr_req && !mem_wr_ack;
      @(negedge clk);
      cyc++;
    end
    pix_valid = 1'b0; mem_wr_ack = 1'b0;
    checks++;
    if (cyc >= BUDGET) begin
      errors++; $display("FAIL %s_timeout: no write_done within %0d cycles", name, BUDGET);
    end
    repeat (3) begin
      @(negedge clk);
      if (write_done) dones++;
    end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL %s_done_count: got %0d want 1", name, dones); end
    checks++;
    if (ridx != nbeats) begin errors++; $display("FAIL %s_req_count: got %0d want %0d", name, ridx, nbeats); end
    checks++;
    if (widx != nbeats * 4) begin errors++; $display("FAIL %s_words: got %0d want %0d", name, widx, nbeats * 4); end
    checks++;
    if (busy !== 1'b0 || ib_count !== 5'd0) begin
      errors++; $display("FAIL %s_idle: busy=%b ib_count=%0d want 0/0", name, busy, ib_count);
    end
  endtask

  task automatic test_reset();
    reset_clk_n = 1'b0; write_start = 1'b0; write_abort = 1'b0; write_addr = '0;
    write_count = '0; pix_valid = 1'b0; pix_data = '0; mem_wr_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_wr_req, pix_ready, busy, write_done} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctl: req/ready/busy/done=%b want 0000", {mem_wr_req, pix_ready, busy, write_done});
    end
    checks++;
    if (mem_wr_addr !== 29'd0 || mem_wr_data !== 128'd0) begin
      errors++; $display("FAIL reset_bus: addr=%h data=%h want 0", mem_wr_addr, mem_wr_data);
    end
    checks++;
    if (ib_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", ib_count); end
    reset_clk_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_wr_req !== 1'b0) begin
      errors++; $display("FAIL reset_release: busy=%b req=%b want 0/0", busy, mem_wr_req);
    end
  endtask

  task automatic test_basic();
    logic [31:0] w[$];
    for (int i = 0; i < 18; i++) w.push_back(32'h0001_0203 + 32'(i) * 32'h0404_0404);
    drive_job("basic", 30'h100, 24'd64, w, 100, 100);
  endtask

  task automatic test_zero_count();
    logic [23:0] cnts[2];
    cnts[0] = 24'd0; cnts[1] = 24'd15;
    for (int t = 0; t < 2; t++) begin
      int seen_req;
      seen_req = 0;
      write_addr = 30'h40; write_count = cnts[t]; write_start = 1'b1; pix_valid = 1'b1; pix_data = $urandom;
      @(negedge clk);
      write_start = 1'b0;
      if (mem_wr_req || pix_ready) seen_req++;
      checks++;
      if (write_done !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL zero%0d_c1: done=%b busy=%b want 0/1", t, write_done, busy);
      end
      @(negedge clk);
      if (mem_wr_req || pix_ready) seen_req++;
      checks++;
      if (write_done !== 1'b1) begin errors++; $display("FAIL zero%0d_c2: done=%b want 1", t, write_done); end
      @(negedge clk);
      if (mem_wr_req || pix_ready) seen_req++;
      checks++;
      if (write_done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL zero%0d_c3: done=%b busy=%b want 0/0", t, write_done, busy);
      end
      checks++;
      if (seen_req != 0) begin errors++; $display("FAIL zero%0d_noreq: req/ready high %0d cycles want 0", t, seen_req); end
      pix_valid = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0]  w[$];
    logic [127:0] exp_d;
    int widx, req_seen, bad;
    widx = 0; req_seen = 0; bad = 0;
    for (int i = 0; i < 80; i++) w.push_back($urandom);
    exp_d = {bswap(w[0]), bswap(w[1]), bswap(w[2]), bswap(w[3])};
    write_addr = 30'h0123_4560; write_count = 24'd512; write_start = 1'b1;
    @(negedge clk);
    write_start = 1'b0;
    for (int c = 0; c < 120; c++) begin
      pix_valid = 1'b1; pix_data = w[widx];
      if (pix_ready) widx++;
      mem_wr_ack = 1'b0;
      if (mem_wr_req) begin
        req_seen++;
        if (mem_wr_addr !== 29'h0091_A2B0 || mem_wr_data !== exp_d) bad++;
      end
      @(negedge clk);
    end
    pix_valid = 1'b0;
    checks++;
    if (req_seen < 100 || bad != 0) begin
      errors++; $display("FAIL bp_hold: req cycles=%0d unstable=%0d want >=100/0", req_seen, bad);
    end
    checks++;
    if (widx != IB_DEPTH * 4 + 3) begin errors++; $display("FAIL bp_words: got %0d want %0d", widx, IB_DEPTH * 4 + 3); end
    checks++;
    if (ib_count !== 5'd16 || pix_ready !== 1'b0) begin
      errors++; $display("FAIL bp_full: ib_count=%0d ready=%b want 16/0", ib_count, pix_ready);
    end
    write_abort = 1'b1;
    @(negedge clk);
    write_abort = 1'b0;
    checks++;
    if (mem_wr_req !== 1'b0 || busy !== 1'b0 || ib_count !== 5'd0) begin
      errors++; $display("FAIL bp_abort: req=%b busy=%b ib_count=%0d want 0/0/0", mem_wr_req, busy, ib_count);
    end
  endtask

  task automatic test_abort();
    logic [31:0] w[$];
    int acks, widx, cyc, dones;
    acks = 0; widx = 0; cyc = 0; dones = 0;
    write_addr = 30'h2000; write_count = 24'd64; write_start = 1'b1;
    @(negedge clk);
    write_start = 1'b0;
    while (acks < 2 && cyc < 200) begin
      pix_valid = (widx < 16); pix_data = $urandom;
      if (pix_valid && pix_ready) widx++;
      mem_wr_ack = 1'b1;
      if (mem_wr_req) acks++;
      @(negedge clk);
      cyc++;
    end
    pix_valid = 1'b0; mem_wr_ack = 1'b0;
    checks++;
    if (acks != 2) begin errors++; $display("FAIL abort_setup: acks=%0d want 2", acks); end
    write_abort = 1'b1;
    @(negedge clk);
    write_abort = 1'b0;
    checks++;
    if (mem_wr_req !== 1'b0 || ib_count !== 5'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_clear: req=%b ib_count=%0d busy=%b want 0/0/0", mem_wr_req, ib_count, busy);
    end
    repeat (10) begin
      if (write_done || mem_wr_req) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL abort_quiet: done/req seen %0d cycles want 0", dones); end
    for (int i = 0; i < 16; i++) w.push_back($urandom);
    drive_job("after_abort", 30'h0000_3000, 24'd64, w, 80, 60);
  endtask

  task automatic test_async_reset();
    int c;
    c = 0;
    write_addr = 30'h400; write_count = 24'd64; write_start = 1'b1;
    @(negedge clk);
    write_start = 1'b0; pix_valid = 1'b1; mem_wr_ack = 1'b0;
    while (!mem_wr_req && c < 50) begin
      pix_data = $urandom;
      @(negedge clk);
      c++;
    end
    pix_valid = 1'b0;
    checks++;
    if (mem_wr_req !== 1'b1) begin errors++; $display("FAIL areset_setup: req=%b want 1", mem_wr_req); end
    #2 reset_clk_n = 1'b0;
    #1;
    checks++;
    if ({mem_wr_req, pix_ready, busy, write_done} !== 4'b0000) begin
      errors++; $display("FAIL areset_ctl: req/ready/busy/done=%b want 0000", {mem_wr_req, pix_ready, busy, write_done});
    end
    checks++;
    if (mem_wr_addr !== 29'd0 || mem_wr_data !== 128'd0 || ib_count !== 5'd0) begin
      errors++; $display("FAIL areset_bus: addr=%h data=%h cnt=%0d want 0", mem_wr_addr, mem_wr_data, ib_count);
    end
    @(negedge clk);
    reset_clk_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL areset_abandon: busy=%b want 0", busy); end
  endtask

  task automatic test_random();
    logic [31:0] w[$];
    logic [23:0] cnt;
    logic [29:0] addr;
    for (int j = 0; j < 6; j++) begin
      w.delete();
      cnt  = 24'($urandom_range(0, 200));
      addr = 30'($urandom);
      for (int i = 0; i < int'(cnt[23:4]) * 4 + 3; i++) w.push_back($urandom);
      drive_job("rand", addr, cnt, w, int'($urandom_range(30, 100)), int'($urandom_range(20, 100)));
    end
    w.delete();
    for (int i = 0; i < 18; i++) w.push_back($urandom);
    drive_job("wrap", 30'h3FFF_FFF0, 24'd64, w, 100, 50);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
